// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detector: loadable pattern/length/target, arm/disarm,
// overlapping or non-overlapping scan of a valid-qualified bit stream, sticky done.
module seq_det_ctrl #(
   parameter int MAXLEN = 8,
   parameter int CNTW   = 8,
   parameter int LW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LW-1:0]     cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic              start,
   input  logic              stop,
   input  logic              ack,
   input  logic              in_valid,
   input  logic              inp,
   output logic              match,
   output logic [CNTW-1:0]   match_cnt,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_ARMED = 2'b01;
   localparam logic [1:0] S_DONE  = 2'b10;

   logic [1:0]        state_reg, state_next;
   logic [MAXLEN-1:0] pat_reg;
   logic [LW-1:0]     len_reg;
   logic              ovl_reg;
   logic [CNTW-1:0]   tgt_reg;
   logic [MAXLEN-2:0] hist_reg;
   logic [LW-1:0]     fill_reg, fill_next;
   logic [CNTW-1:0]   cnt_reg;
   logic              match_reg;

   logic [MAXLEN-1:0] mask;
   logic [MAXLEN-1:0] window;
   logic [CNTW:0]     cnt_inc;
   logic              len_ok, fill_ok, accept, hit, hit_last, arm;

   // Only the low len bits of the window take part in the comparison.
   generate
      for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
         assign mask[gi] = ({1'b0, len_reg} > (LW+1)'(gi));
      end
   endgenerate

   assign window   = {hist_reg, inp};
   assign len_ok   = (len_reg != '0) && ({1'b0, len_reg} <= (LW+1)'(MAXLEN));
   assign fill_ok  = (({1'b0, fill_reg} + (LW+1)'(1)) >= {1'b0, len_reg});
   assign accept   = (state_reg == S_ARMED) && in_valid;
   assign hit      = accept && fill_ok && ((window & mask) == (pat_reg & mask));
   assign cnt_inc  = {1'b0, cnt_reg} + (CNTW+1)'(1);
   assign hit_last = hit && (tgt_reg != '0) && (cnt_inc == {1'b0, tgt_reg});
   assign arm      = (state_reg == S_IDLE) && start && !stop && len_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (arm) state_next = S_ARMED;
         S_ARMED: begin
            // Reaching the target outranks a simultaneous stop.
            if (hit_last)  state_next = S_DONE;
            else if (stop) state_next = S_IDLE;
         end
         S_DONE:  if (ack) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == S_ARMED);
      done = (state_reg == S_DONE);
   end

   always_comb begin
      fill_next = fill_reg;
      if (hit && !ovl_reg)       fill_next = '0;
      else if (fill_reg < len_reg) fill_next = fill_reg + LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_reg   <= MAXLEN'(5'b11010);
         len_reg   <= LW'(5);
         ovl_reg   <= 1'b1;
         tgt_reg   <= CNTW'(1);
         hist_reg  <= '0;
         fill_reg  <= '0;
         cnt_reg   <= '0;
         match_reg <= 1'b0;
      end else begin
         match_reg <= hit;
         if ((state_reg == S_IDLE) && cfg_we) begin
            pat_reg <= cfg_pattern;
            len_reg <= cfg_len;
            ovl_reg <= cfg_overlap;
            tgt_reg <= cfg_target;
         end
         if (arm) begin
            hist_reg <= '0;
            fill_reg <= '0;
            cnt_reg  <= '0;
         end else if (accept) begin
            hist_reg <= window[MAXLEN-2:0];
            fill_reg <= fill_next;
            if (hit && (cnt_reg != '1)) cnt_reg <= cnt_reg + CNTW'(1);
         end
      end
   end

   assign match     = match_reg;
   assign match_cnt = cnt_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_det_ctrl;

   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_overlap, start, stop, ack, in_valid, inp;
   logic [7:0] cfg_pattern, cfg_target;
   logic [3:0] cfg_len;
   logic       match, busy, done;
   logic [7:0] match_cnt;
   logic [1:0] state;

   int n_chk  = 0;
   int n_fail = 0;

   seq_det_ctrl #(.MAXLEN(8), .CNTW(8), .LW(4)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
      .start(start), .stop(stop), .ack(ack), .in_valid(in_valid), .inp(inp),
      .match(match), .match_cnt(match_cnt), .busy(busy), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: state as a small integer, history as a queue of fresh bits.
   int   m_state;
   bit   m_valid = 0;
   bit   m_match;
   int   m_cnt;
   bit [7:0] m_pat;
   int   m_len;
   bit   m_ovl;
   int   m_tgt;
   bit   m_bits[$];

   task automatic model_step();
      bit hit;
      int old_cnt;
      if (rst) begin
         m_state = 0; m_match = 0; m_cnt = 0; m_bits.delete();
         m_pat = 8'b00011010; m_len = 5; m_ovl = 1; m_tgt = 1;
         m_valid = 1;
      end else if (m_valid) begin
         case (m_state)
            0: begin
               m_match = 0;
               if (start && !stop && m_len >= 1 && m_len <= 8) begin
                  m_state = 1; m_bits.delete(); m_cnt = 0;
               end
               if (cfg_we) begin
                  m_pat = cfg_pattern; m_len = int'(cfg_len);
                  m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
               end
            end
            1: begin
               hit = 0;
               if (in_valid) begin
                  m_bits.push_back(inp);
                  while (m_bits.size() > m_len) void'(m_bits.pop_front());
                  if (m_bits.size() == m_len) begin
                     hit = 1;
                     for (int k = 0; k < m_len; k++)
                        if (m_bits[k] != m_pat[m_len-1-k]) hit = 0;
                  end
               end
               m_match = hit;
               old_cnt = m_cnt;
               if (hit) begin
                  if (m_cnt != 255) m_cnt++;
                  if (!m_ovl) m_bits.delete();
               end
               if (hit && m_tgt != 0 && old_cnt + 1 == m_tgt) m_state = 2;
               else if (stop) m_state = 0;
            end
            default: begin
               m_match = 0;
               if (ack) m_state = 0;
            end
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("model_match", 32'(match), 32'(m_match));
         chk("model_cnt", 32'(match_cnt), 32'(m_cnt));
         chk("model_state", 32'(state), 32'(m_state));
         chk("model_busy", 32'(busy), 32'(m_state == 1));
         chk("model_done", 32'(done), 32'(m_state == 2));
      end
   end

   task automatic send(input logic v, input logic b);
      in_valid = v; inp = b;
      @(negedge clk);
      in_valid = 1'b0; inp = 1'b0;
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1; @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1; @(negedge clk); ack = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
      start = 0; stop = 0; ack = 0; in_valid = 0; inp = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_state", 32'(state), 0);
      chk("rst_cnt", 32'(match_cnt), 0);
      chk("rst_busy_done", {busy, done, match}, 0);

      // Default pattern 11010, target 1
      pulse_start();
      chk("t1_armed", 32'(state), 1);
      stream(16'b11010, 5);
      chk("t1_match", 32'(match), 1);
      chk("t1_cnt", 32'(match_cnt), 1);
      chk("t1_done", {done, state}, 3'b110);
      @(negedge clk);
      chk("t1_pulse_one", 32'(match), 0);
      pulse_ack();
      chk("t1_ack", 32'(state), 0);
      chk("t1_cnt_kept", 32'(match_cnt), 1);

      // Overlapping 101
      cfg(8'b101, 4'd3, 1'b1, 8'd0);
      pulse_start();
      stream(16'b10101, 5);
      chk("t2_ovl_cnt", 32'(match_cnt), 2);
      chk("t2_state", 32'(state), 1);
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      chk("t2_stopped", 32'(state), 0);

      // Non-overlapping 101
      cfg(8'b101, 4'd3, 1'b0, 8'd0);
      pulse_start();
      stream(16'b10101, 5);
      chk("t3_novl_cnt", 32'(match_cnt), 1);
      stop = 1'b1; @(negedge clk); stop = 1'b0;

      // Bubbles, and a config write while armed must be dropped
      cfg(8'b00011010, 4'd5, 1'b1, 8'd1);
      pulse_start();
      send(1, 1); send(0, 0); send(1, 1); send(0, 1);
      cfg(8'b101, 4'd3, 1'b0, 8'd0);
      send(1, 0); send(1, 1);
      chk("t4_no_early", 32'(match_cnt), 0);
      send(0, 0); send(0, 1);
      send(1, 0);
      chk("t4_match", 32'(match), 1);
      chk("t4_done", 32'(state), 2);
      pulse_ack();

      // Target 3, then a fourth pattern in DONE
      cfg(8'b101, 4'd3, 1'b1, 8'd3);
      pulse_start();
      stream(16'b1010101, 7);
      chk("t5_cnt", 32'(match_cnt), 3);
      chk("t5_done", 32'(state), 2);
      stream(16'b01, 2);
      chk("t5_no_pulse", 32'(match), 0);
      chk("t5_cnt_hold", 32'(match_cnt), 3);
      pulse_ack();

      // Stop coinciding with a hit
      cfg(8'b101, 4'd3, 1'b1, 8'd0);
      pulse_start();
      stream(16'b10, 2);
      stop = 1'b1; send(1, 1); stop = 1'b0;
      chk("t6_match", 32'(match), 1);
      chk("t6_cnt", 32'(match_cnt), 1);
      chk("t6_idle", 32'(state), 0);

      // start+stop in IDLE
      start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
      chk("t7_idle", 32'(state), 0);

      // Illegal lengths
      cfg(8'b101, 4'd0, 1'b1, 8'd0);
      pulse_start();
      chk("t8_len0", 32'(state), 0);
      cfg(8'b101, 4'd9, 1'b1, 8'd0);
      pulse_start();
      chk("t8_len9", 32'(state), 0);

      // Mid-run reset restores config defaults
      cfg(8'b101, 4'd3, 1'b1, 8'd0);
      pulse_start();
      stream(16'b100, 3);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("t9_rst_outs", {match, match_cnt, busy, done, state}, 0);
      pulse_start();
      stream(16'b11010, 5);
      chk("t9_match", 32'(match), 1);
      chk("t9_done", 32'(state), 2);
      pulse_ack();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable serial-pattern detection controller for the sequence-detector family.
- Holds a loadable pattern of up to MAXLEN bits, arms and disarms detection, and scans a valid-qualified serial bit stream in overlapping or non-overlapping mode.
- Counts matches toward a programmable target and raises a sticky done flag that a host clears with an acknowledge.
- Sits between a host/config master and the serial input source, and replaces fixed-pattern detectors.

Parameters:
- MAXLEN, 8, maximum pattern length in bits (2..16).
- CNTW, 8, width of the match counter and target.
- LW, 4, width of cfg_len; must hold the value MAXLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  MAXLEN  pattern bits; bit [cfg_len-1] is the first bit received.
- cfg_len  in  LW  pattern length, legal range 1..MAXLEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match.
- cfg_target  in  CNTW  match count that ends the run; 0 = free-run, never done.
- start  in  1  arm request.
- stop  in  1  disarm request.
- ack  in  1  clears done.
- in_valid  in  1  inp qualifier.
- inp  in  1  serial data bit.
- match  out  1  one-cycle match pulse.
- match_cnt  out  CNTW  matches counted in the current or last run.
- busy  out  1  high in ARMED.
- done  out  1  high in DONE.
- state  out  2  encoding IDLE=00, ARMED=01, DONE=10.

Behaviour:
- Reset, the cycle after rst is sampled high:
  - state=IDLE; match=0, match_cnt=0, busy=0, done=0; history and fill count cleared.
  - Config reset values: pattern=11010 (len 5, upper bits 0), overlap=1, target=1.
- All outputs are registered. busy and done decode the state register.
- IDLE:
  - cfg_we loads all four config fields at the edge.
  - start with a legal stored len (1..MAXLEN) and stop=0: next state is ARMED; history, fill count and match_cnt are cleared at that edge.
  - start is ignored if the stored len is 0 or greater than MAXLEN.
  - start and stop in the same cycle: stop wins, state stays IDLE.
- ARMED:
  - cfg_we is ignored.
  - On each in_valid: shift inp into the LSB of the history register; the fill count increments, saturating at len.
  - A hit requires both of the following in the same accepting cycle:
    - fill count + 1 >= len;
    - the low len bits of {history, inp} equal the low len bits of the pattern.
  - On a hit:
    - match is high for exactly the cycle after the accepting edge.
    - match_cnt increments at that edge and saturates at all-ones.
    - If overlap=0, the fill count is cleared to 0, so the next match needs len fresh bits.
  - Cycles with in_valid=0: no shift, no match, and the fill count holds.
  - Hit with match_cnt+1 == target and target != 0: next state is DONE at the same edge.
  - stop: next state is IDLE and match_cnt is retained.
  - stop together with a hit: the hit is still counted and pulsed, then state goes to IDLE. A hit that reaches target goes to DONE instead of IDLE.
- DONE:
  - done=1; start, cfg_we and in_valid are ignored.
  - ack: next state is IDLE; match_cnt is retained.
- rst asserted in any state aborts the run and restores all reset values, including the config defaults.

Test Plan:
- Reset defaults, start, then stream 1,1,0,1,0 with in_valid=1 -> match high for one cycle after the 5th bit; match_cnt=1; done=1, state=10; ack -> state=00.
- Overlap: cfg pattern=101, len=3, overlap=1, target=0; stream 1,0,1,0,1 -> match_cnt=2 (hits on bits 3 and 5), state stays 01.
- Non-overlap: same stream with overlap=0 -> match_cnt=1.
- in_valid gaps: default 11010 with in_valid=0 bubbles interleaved -> match only after the 5th valid bit; cfg_we while ARMED does not change the pattern.
- Corner cases:
  - target=3: exactly 3 matches lead to DONE, and a 4th pattern in DONE does not pulse match.
  - stop in the same cycle as a hit: match_cnt increments and state goes to 00.
  - start+stop in IDLE: state stays 00.
  - cfg_len=0 then start: state stays 00.
- Mid-run rst: after 3 bits, assert rst -> all outputs 0 and config back to 11010/len 5; the following start with 11010 detects correctly.
